// File: rtl/ysyx_24100029_axi_pkg.sv
// Shared types for the AXI4 port arbiter: FSM states, owner codes,
// bus widths and the slave-to-master return bundle.
package ysyx_24100029_axi_pkg;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IDW = 4;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_RESP
  } arb_state_e;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  typedef struct packed {
    logic           arready;
    logic           awready;
    logic           wready;
    logic           rvalid;
    logic [DW-1:0]  rdata;
    logic [1:0]     rresp;
    logic           rlast;
    logic [IDW-1:0] rid;
    logic           bvalid;
    logic [1:0]     bresp;
    logic [IDW-1:0] bid;
  } slv_ret_t;

endpackage

// File: rtl/ysyx_24100029_axi4_if.sv
// AXI4 bundle (AR, AW, W, R, B). master drives requests,
// slave drives ready/response signals.
interface axi4_if;
  import ysyx_24100029_axi_pkg::*;

  logic           arvalid;
  logic           arready;
  logic [AW-1:0]  araddr;
  logic [IDW-1:0] arid;
  logic [7:0]     arlen;
  logic [2:0]     arsize;
  logic [1:0]     arburst;

  logic           awvalid;
  logic           awready;
  logic [AW-1:0]  awaddr;
  logic [IDW-1:0] awid;
  logic [7:0]     awlen;
  logic [2:0]     awsize;
  logic [1:0]     awburst;

  logic           wvalid;
  logic           wready;
  logic [DW-1:0]  wdata;
  logic [DW/8-1:0] wstrb;
  logic           wlast;

  logic           rvalid;
  logic           rready;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic [IDW-1:0] rid;

  logic           bvalid;
  logic           bready;
  logic [1:0]     bresp;
  logic [IDW-1:0] bid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready,
    input  bvalid, bresp, bid,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready,
    output bvalid, bresp, bid,
    input  bready
  );

endinterface

// File: rtl/ysyx_24100029_rr_arb2.sv
// Two-way grant: sole requester wins; on a tie the master not granted
// last wins, or M1 always wins when fixed is set. Ports: req, last, fixed -> gnt.
module ysyx_24100029_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (&req) gnt = (fixed | ~last) ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/ysyx_24100029_axi_arbiter.sv
// Shares one AXI4 port between icache (m0_axi) and LSU (m1_axi), one
// transaction at a time. Ports: clock, reset, m0/m1/out_axi, busy, owner.
module ysyx_24100029_axi_arbiter
  import ysyx_24100029_axi_pkg::*;
#(
  parameter bit FIXED_PRIO  = 1'b0,
  parameter bit M1_WR_FIRST = 1'b1
) (
  input  logic    clock,
  input  logic    reset,
  axi4_if.slave   m0_axi,
  axi4_if.slave   m1_axi,
  axi4_if.master  out_axi,
  output logic    busy,
  output logic    owner
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;

  logic [1:0] req, gnt;
  logic       sel_ar, sel_aw, take_wr;
  logic       ar_fire, aw_fire, w_fire;
  logic       r_end, b_fire;
  slv_ret_t   ret;

  assign req[0] = m0_axi.arvalid | m0_axi.awvalid;
  assign req[1] = m1_axi.arvalid | m1_axi.awvalid;

  ysyx_24100029_rr_arb2 u_arb (
    .req   (req),
    .last  (last_q),
    .fixed (FIXED_PRIO),
    .gnt   (gnt)
  );

  assign sel_ar  = gnt[1] ? m1_axi.arvalid : m0_axi.arvalid;
  assign sel_aw  = gnt[1] ? m1_axi.awvalid : m0_axi.awvalid;
  assign take_wr = sel_aw & (~sel_ar | M1_WR_FIRST);

  assign ar_fire = out_axi.arvalid & out_axi.arready;
  assign aw_fire = out_axi.awvalid & out_axi.awready;
  assign w_fire  = out_axi.wvalid & out_axi.wready
                 & out_axi.wlast;
  assign r_end   = out_axi.rvalid & out_axi.rready
                 & out_axi.rlast;
  assign b_fire  = out_axi.bvalid & out_axi.bready;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    aw_done_d = aw_done_q | aw_fire;
    w_done_d  = w_done_q | w_fire;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = gnt[1];
          last_d  = gnt[1];
          state_d = take_wr ? WR_ADDR : RD_ADDR;
        end
      end
      RD_ADDR: if (ar_fire) state_d = RD_DATA;
      RD_DATA: if (r_end) state_d = IDLE;
      WR_ADDR: begin
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (b_fire) begin
          state_d   = IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= OWNER_IFU;
      last_q    <= OWNER_IFU;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Reset gates the muxes so the slave side goes quiet immediately.
  always_comb begin
    out_axi.arvalid = 1'b0;
    out_axi.araddr  = '0;
    out_axi.arid    = '0;
    out_axi.arlen   = '0;
    out_axi.arsize  = '0;
    out_axi.arburst = '0;
    out_axi.awvalid = 1'b0;
    out_axi.awaddr  = '0;
    out_axi.awid    = '0;
    out_axi.awlen   = '0;
    out_axi.awsize  = '0;
    out_axi.awburst = '0;
    out_axi.wvalid  = 1'b0;
    out_axi.wdata   = '0;
    out_axi.wstrb   = '0;
    out_axi.wlast   = 1'b0;
    out_axi.rready  = 1'b0;
    out_axi.bready  = 1'b0;
    ret             = '0;
    if (!reset) begin
      unique case (state_q)
        RD_ADDR: begin
          out_axi.arvalid = owner_q ? m1_axi.arvalid : m0_axi.arvalid;
          out_axi.araddr  = owner_q ? m1_axi.araddr  : m0_axi.araddr;
          out_axi.arid    = owner_q ? m1_axi.arid    : m0_axi.arid;
          out_axi.arlen   = owner_q ? m1_axi.arlen   : m0_axi.arlen;
          out_axi.arsize  = owner_q ? m1_axi.arsize  : m0_axi.arsize;
          out_axi.arburst = owner_q ? m1_axi.arburst : m0_axi.arburst;
          ret.arready     = out_axi.arready;
        end
        RD_DATA: begin
          out_axi.rready = owner_q ? m1_axi.rready : m0_axi.rready;
          ret.rvalid     = out_axi.rvalid;
          ret.rdata      = out_axi.rdata;
          ret.rresp      = out_axi.rresp;
          ret.rlast      = out_axi.rlast;
          ret.rid        = out_axi.rid;
        end
        WR_ADDR: begin
          out_axi.awvalid = ~aw_done_q
                          & (owner_q ? m1_axi.awvalid : m0_axi.awvalid);
          out_axi.awaddr  = owner_q ? m1_axi.awaddr  : m0_axi.awaddr;
          out_axi.awid    = owner_q ? m1_axi.awid    : m0_axi.awid;
          out_axi.awlen   = owner_q ? m1_axi.awlen   : m0_axi.awlen;
          out_axi.awsize  = owner_q ? m1_axi.awsize  : m0_axi.awsize;
          out_axi.awburst = owner_q ? m1_axi.awburst : m0_axi.awburst;
          out_axi.wvalid  = ~w_done_q
                          & (owner_q ? m1_axi.wvalid : m0_axi.wvalid);
          out_axi.wdata   = owner_q ? m1_axi.wdata : m0_axi.wdata;
          out_axi.wstrb   = owner_q ? m1_axi.wstrb : m0_axi.wstrb;
          out_axi.wlast   = owner_q ? m1_axi.wlast : m0_axi.wlast;
          ret.awready     = out_axi.awready & ~aw_done_q;
          ret.wready      = out_axi.wready & ~w_done_q;
        end
        WR_RESP: begin
          out_axi.bready = owner_q ? m1_axi.bready : m0_axi.bready;
          ret.bvalid     = out_axi.bvalid;
          ret.bresp      = out_axi.bresp;
          ret.bid        = out_axi.bid;
        end
        default: ;
      endcase
    end
  end

  assign m0_axi.arready = ~owner_q & ret.arready;
  assign m0_axi.awready = ~owner_q & ret.awready;
  assign m0_axi.wready  = ~owner_q & ret.wready;
  assign m0_axi.rvalid  = ~owner_q & ret.rvalid;
  assign m0_axi.rdata   = owner_q ? '0 : ret.rdata;
  assign m0_axi.rresp   = owner_q ? '0 : ret.rresp;
  assign m0_axi.rlast   = ~owner_q & ret.rlast;
  assign m0_axi.rid     = owner_q ? '0 : ret.rid;
  assign m0_axi.bvalid  = ~owner_q & ret.bvalid;
  assign m0_axi.bresp   = owner_q ? '0 : ret.bresp;
  assign m0_axi.bid     = owner_q ? '0 : ret.bid;

  assign m1_axi.arready = owner_q & ret.arready;
  assign m1_axi.awready = owner_q & ret.awready;
  assign m1_axi.wready  = owner_q & ret.wready;
  assign m1_axi.rvalid  = owner_q & ret.rvalid;
  assign m1_axi.rdata   = owner_q ? ret.rdata : '0;
  assign m1_axi.rresp   = owner_q ? ret.rresp : '0;
  assign m1_axi.rlast   = owner_q & ret.rlast;
  assign m1_axi.rid     = owner_q ? ret.rid : '0;
  assign m1_axi.bvalid  = owner_q & ret.bvalid;
  assign m1_axi.bresp   = owner_q ? ret.bresp : '0;
  assign m1_axi.bid     = owner_q ? ret.bid : '0;

  assign busy  = (state_q != IDLE);
  assign owner = owner_q;

`ifdef Performance_Count
  logic [31:0] m0_wait, m1_wait;

  always_ff @(posedge clock) begin
    if (reset) begin
      m0_wait <= '0;
      m1_wait <= '0;
    end else begin
      if (req[0] && !(busy && owner_q == OWNER_IFU))
        m0_wait <= m0_wait + 32'd1;
      if (req[1] && !(busy && owner_q == OWNER_LSU))
        m1_wait <= m1_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_24100029_axi_arbiter.sv
// Directed bench for the AXI arbiter: reads, ties, writes,
// mid-burst reset and stalled second master.
module tb_ysyx_24100029_axi_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy, owner;
  int   n_vec = 0;
  int   n_err = 0;

  axi4_if m0 ();
  axi4_if m1 ();
  axi4_if sl ();

  ysyx_24100029_axi_arbiter dut (
    .clock   (clock),
    .reset   (reset),
    .m0_axi  (m0),
    .m1_axi  (m1),
    .out_axi (sl),
    .busy    (busy),
    .owner   (owner)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_master(input logic which);
    if (which) begin
      m1.arvalid = 0; m1.araddr = 0; m1.arid = 0; m1.arlen = 0;
      m1.arsize = 0; m1.arburst = 0; m1.awvalid = 0; m1.awaddr = 0;
      m1.awid = 0; m1.awlen = 0; m1.awsize = 0; m1.awburst = 0;
      m1.wvalid = 0; m1.wdata = 0; m1.wstrb = 0; m1.wlast = 0;
      m1.rready = 0; m1.bready = 0;
    end else begin
      m0.arvalid = 0; m0.araddr = 0; m0.arid = 0; m0.arlen = 0;
      m0.arsize = 0; m0.arburst = 0; m0.awvalid = 0; m0.awaddr = 0;
      m0.awid = 0; m0.awlen = 0; m0.awsize = 0; m0.awburst = 0;
      m0.wvalid = 0; m0.wdata = 0; m0.wstrb = 0; m0.wlast = 0;
      m0.rready = 0; m0.bready = 0;
    end
  endtask

  task automatic clr_slave();
    sl.arready = 0; sl.awready = 0; sl.wready = 0;
    sl.rvalid = 0; sl.rdata = 0; sl.rresp = 0; sl.rlast = 0; sl.rid = 0;
    sl.bvalid = 0; sl.bresp = 0; sl.bid = 0;
  endtask

  // Called one cycle after the grant edge (state RD_ADDR).
  task automatic rd_txn(input logic own, input logic [31:0] addr,
                        input int beats);
    chk("rd_busy", busy, 1);
    chk("rd_owner", owner, own);
    chk("rd_arvalid", sl.arvalid, 1);
    chk("rd_araddr", sl.araddr, addr);
    sl.arready = 1;
    #1;
    chk("rd_arready_own", own ? m1.arready : m0.arready, 1);
    chk("rd_arready_oth", own ? m0.arready : m1.arready, 0);
    tick();
    if (own) begin m1.arvalid = 0; m1.rready = 1; end
    else begin m0.arvalid = 0; m0.rready = 1; end
    sl.arready = 0;
    for (int i = 0; i < beats; i++) begin
      sl.rvalid = 1;
      sl.rdata  = addr + 32'(i);
      sl.rlast  = (i == beats - 1);
      sl.rid    = 4'(i);
      #1;
      chk("rd_rvalid_own", own ? m1.rvalid : m0.rvalid, 1);
      chk("rd_rdata", own ? m1.rdata : m0.rdata, addr + 32'(i));
      chk("rd_rvalid_oth", own ? m0.rvalid : m1.rvalid, 0);
      chk("rd_rready", sl.rready, 1);
      tick();
    end
    sl.rvalid = 0; sl.rlast = 0;
    if (own) m1.rready = 0; else m0.rready = 0;
    #1;
    chk("rd_done_busy", busy, 0);
  endtask

`ifdef Performance_Count
  logic [31:0] w0;
`endif

  initial begin
    clr_master(0);
    clr_master(1);
    clr_slave();

    // Reset state, with a pending request that must not leak out
    m0.arvalid = 1; m0.araddr = 32'h3000_0000; m0.arlen = 8'd3;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_arvalid", sl.arvalid, 0);

    // T1: M0 alone, 4-beat read
    reset = 0;
    #1;
    chk("t1_idle_arvalid", sl.arvalid, 0);
    tick();
    chk("t1_arlen", sl.arlen, 3);
    rd_txn(0, 32'h3000_0000, 4);

    // T2: tie after an M0 grant -> M1, then held M0
    m0.arvalid = 1; m0.araddr = 32'h0000_0100;
    m1.arvalid = 1; m1.araddr = 32'h0000_0200;
    tick();
    rd_txn(1, 32'h0000_0200, 1);
    tick();
    rd_txn(0, 32'h0000_0100, 1);
    m0.arvalid = 1; m0.araddr = 32'h0000_0104;
    m1.arvalid = 1; m1.araddr = 32'h0000_0204;
    tick();
    rd_txn(1, 32'h0000_0204, 1);
    m1.arvalid = 1; m1.araddr = 32'h0000_0208;
    tick();
    rd_txn(0, 32'h0000_0104, 1);
    tick();
    rd_txn(1, 32'h0000_0208, 1);

    // T3: M1 write, W accepted two cycles before AW
    m1.awvalid = 1; m1.awaddr = 32'h8000_0010; m1.awid = 4'h3;
    m1.wvalid = 1; m1.wdata = 32'hDEAD_BEEF; m1.wstrb = 4'hF;
    m1.wlast = 1; m1.bready = 1;
    tick();
    chk("t3_owner", owner, 1);
    chk("t3_awvalid", sl.awvalid, 1);
    chk("t3_awaddr", sl.awaddr, 32'h8000_0010);
    chk("t3_wvalid", sl.wvalid, 1);
    chk("t3_wdata", sl.wdata, 32'hDEAD_BEEF);
    chk("t3_wstrb", sl.wstrb, 4'hF);
    sl.wready = 1;
    #1;
    chk("t3_m1_wready", m1.wready, 1);
    chk("t3_m0_wready", m0.wready, 0);
    tick();
    sl.wready = 0;
    #1;
    chk("t3_w_masked", sl.wvalid, 0);
    chk("t3_aw_held", sl.awvalid, 1);
    tick();
    sl.awready = 1;
    #1;
    chk("t3_m1_awready", m1.awready, 1);
    tick();
    m1.awvalid = 0; m1.wvalid = 0; m1.wlast = 0;
    sl.awready = 0;
    #1;
    chk("t3_aw_single", sl.awvalid, 0);
    chk("t3_wr_busy", busy, 1);
    sl.bvalid = 1; sl.bresp = 2'b00; sl.bid = 4'h3;
    #1;
    chk("t3_m1_bvalid", m1.bvalid, 1);
    chk("t3_m1_bresp", m1.bresp, 0);
    chk("t3_m1_bid", m1.bid, 4'h3);
    chk("t3_m0_bvalid", m0.bvalid, 0);
    chk("t3_bready", sl.bready, 1);
    tick();
    sl.bvalid = 0; sl.bid = 0;
    m1.bready = 0;
    #1;
    chk("t3_idle", busy, 0);

    // T4: M1 AR and AW together -> write first
    m1.arvalid = 1; m1.araddr = 32'h8000_0300;
    m1.awvalid = 1; m1.awaddr = 32'h8000_0020;
    m1.wvalid = 1; m1.wdata = 32'h1234_5678; m1.wstrb = 4'h3;
    m1.wlast = 1; m1.bready = 1;
    tick();
    chk("t4_awvalid", sl.awvalid, 1);
    chk("t4_arvalid", sl.arvalid, 0);
    sl.awready = 1; sl.wready = 1;
    tick();
    m1.awvalid = 0; m1.wvalid = 0; m1.wlast = 0;
    sl.awready = 0; sl.wready = 0;
    sl.bvalid = 1; sl.bresp = 2'b10;
    #1;
    chk("t4_bresp", m1.bresp, 2'b10);
    tick();
    sl.bvalid = 0; sl.bresp = 0;
    m1.bready = 0;
    #1;
    chk("t4_gap_busy", busy, 0);
    chk("t4_gap_arvalid", sl.arvalid, 0);
    tick();
    rd_txn(1, 32'h8000_0300, 1);

    // T5: reset during beat 2 of a 4-beat M0 read
    m0.arvalid = 1; m0.araddr = 32'h3000_0040; m0.arlen = 8'd3;
    tick();
    sl.arready = 1;
    tick();
    m0.arvalid = 0; m0.rready = 1;
    sl.arready = 0;
    for (int i = 0; i < 2; i++) begin
      sl.rvalid = 1; sl.rlast = 0;
      tick();
    end
    sl.rvalid = 1;
    reset = 1;
    #1;
    chk("t5_rready_drop", sl.rready, 0);
    chk("t5_m0_rvalid", m0.rvalid, 0);
    tick();
    chk("t5_busy", busy, 0);
    chk("t5_owner", owner, 0);
    chk("t5_arvalid", sl.arvalid, 0);
    reset = 0;
    sl.rvalid = 0;
    m0.rready = 0;
    m1.arvalid = 1; m1.araddr = 32'h8000_0100;
    tick();
    rd_txn(1, 32'h8000_0100, 2);

    // T6: M1 arrives mid-burst of an M0 read
    m0.arvalid = 1; m0.araddr = 32'h3000_0080; m0.arlen = 8'd1;
    tick();
    sl.arready = 1;
    tick();
    m0.arvalid = 0; m0.rready = 1;
    m1.arvalid = 1; m1.araddr = 32'h8000_0200;
`ifdef Performance_Count
    w0 = dut.m1_wait;
`endif
    for (int i = 0; i < 2; i++) begin
      sl.rvalid = 1; sl.rlast = (i == 1);
      #1;
      chk("t6_m1_arready", m1.arready, 0);
      chk("t6_out_arvalid", sl.arvalid, 0);
      tick();
    end
    sl.rvalid = 0; sl.rlast = 0;
    sl.arready = 0;
    m0.rready = 0;
    #1;
    chk("t6_idle", busy, 0);
    tick();
`ifdef Performance_Count
    chk("t6_m1_wait", dut.m1_wait - w0, 32'd3);
`endif
    rd_txn(1, 32'h8000_0200, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
